// File: rtl/alu_serial_cmd_receiver.sv
// Serial command receiver: deframes 11-bit frames on i_sin, collects 8 operand
// bytes plus a CMD byte, checks count/CRC4/opcode and strobes a command or an error.
module alu_serial_cmd_receiver (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sin,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [2:0]  o_op,
    output logic        o_cmd_valid,
    output logic        o_err_valid,
    output logic [2:0]  o_err_flags
);

    // state  | meaning
    // IDLE   | waiting for a start bit (sin = 0)
    // TYPE   | latching the type bit (1 = CMD, 0 = DATA)
    // BITS   | shifting the 8 payload bits, MSB first
    // STOP   | sampling the stop bit and acting on the completed frame
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TYPE = 2'd1;
    localparam logic [1:0] S_BITS = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic        r_type;
    logic [7:0]  r_shift;
    logic [3:0]  r_byte_cnt;
    logic        r_frame_err;
    logic [63:0] r_buf;

    logic        r_pend;
    logic [2:0]  r_pend_flags;
    logic [2:0]  r_pend_op;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic        r_cmd_valid;
    logic        r_err_valid;
    logic [2:0]  r_err_flags;

    logic [2:0]  w_cmd_op;
    logic [3:0]  w_cmd_crc;
    logic [3:0]  w_crc_calc;
    logic        w_err_data;
    logic        w_err_crc;
    logic        w_err_op;

    // CRC4, polynomial x^4+x+1, zero seed, MSB of the message first.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    assign w_cmd_op   = r_shift[6:4];
    assign w_cmd_crc  = r_shift[3:0];
    assign w_crc_calc = crc4({r_buf, 1'b1, w_cmd_op});
    assign w_err_data = (r_byte_cnt != 4'd8) | r_frame_err | ~i_sin;
    assign w_err_crc  = ~w_err_data & (w_cmd_crc != w_crc_calc);
    // Legal opcodes 000/001/100/101 are exactly those with op[1] clear.
    assign w_err_op   = ~w_err_data & ~w_err_crc & w_cmd_op[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_type       <= 1'b0;
            r_shift      <= 8'd0;
            r_byte_cnt   <= 4'd0;
            r_frame_err  <= 1'b0;
            r_buf        <= 64'd0;
            r_pend       <= 1'b0;
            r_pend_flags <= 3'd0;
            r_pend_op    <= 3'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_op         <= 3'd0;
            r_cmd_valid  <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err_flags  <= 3'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_flags <= 3'd0;
            r_pend      <= 1'b0;

            // Verdict from the CMD stop-bit edge is published one edge later.
            if (r_pend) begin
                if (r_pend_flags == 3'd0) begin
                    r_cmd_valid <= 1'b1;
                    r_b         <= r_buf[63:32];
                    r_a         <= r_buf[31:0];
                    r_op        <= r_pend_op;
                end else begin
                    r_err_valid <= 1'b1;
                    r_err_flags <= r_pend_flags;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!i_sin) begin
                        r_state <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    r_type    <= i_sin;
                    r_bit_cnt <= 3'd7;
                    r_state   <= S_BITS;
                end
                S_BITS: begin
                    r_shift <= {r_shift[6:0], i_sin};
                    if (r_bit_cnt == 3'd0) begin
                        r_state <= S_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    if (r_type) begin
                        r_pend       <= 1'b1;
                        r_pend_flags <= {w_err_data, w_err_crc, w_err_op};
                        r_pend_op    <= w_cmd_op;
                        r_byte_cnt   <= 4'd0;
                        r_frame_err  <= 1'b0;
                    end else if (!i_sin) begin
                        r_frame_err <= 1'b1;
                    end else if (r_byte_cnt < 4'd8) begin
                        for (int k = 0; k < 8; k++) begin
                            if (r_byte_cnt == 4'(k)) begin
                                r_buf[63 - 8*k -: 8] <= r_shift;
                            end
                        end
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end else begin
                        r_byte_cnt <= 4'd9;
                    end
                end
            endcase
        end
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_op        = r_op;
    assign o_cmd_valid = r_cmd_valid;
    assign o_err_valid = r_err_valid;
    assign o_err_flags = r_err_flags;

endmodule

// File: tb/tb_alu_serial_cmd_receiver.sv
// Bench for alu_serial_cmd_receiver: directed and random commands checked against
// a byte-list reference model with a long-division CRC4.
module tb_alu_serial_cmd_receiver;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        cmd_valid;
    logic        err_valid;
    logic [2:0]  err_flags;

    int n_chk  = 0;
    int n_pass = 0;
    int n_cmdp = 0;
    int n_errp = 0;
    int n_both = 0;

    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;
    logic [2:0]  exp_op = 3'd0;

    logic [7:0] q_byte[$];
    logic       q_stop[$];

    alu_serial_cmd_receiver dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sin       (sin),
        .o_a         (a),
        .o_b         (b),
        .o_op        (op),
        .o_cmd_valid (cmd_valid),
        .o_err_valid (err_valid),
        .o_err_flags (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) n_cmdp++;
            if (err_valid) n_errp++;
            if (cmd_valid && err_valid) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Remainder of M(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [31:0] bb, input logic [31:0] aa,
                                           input logic [2:0] o);
        logic [71:0] m;
        m = {bb, aa, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = f[i];
        end
    endtask

    task automatic load_ab(input logic [31:0] bb, input logic [31:0] aa);
        logic [63:0] v;
        v = {bb, aa};
        q_byte.delete();
        q_stop.delete();
        for (int i = 0; i < 8; i++) begin
            q_byte.push_back(v[63 - 8*i -: 8]);
            q_stop.push_back(1'b1);
        end
    endtask

    task automatic do_command(input string tag, input logic [2:0] o, input logic [3:0] crc,
                              input logic cmd_stop);
        int          cnt;
        logic        ferr;
        logic [7:0]  bytes[8];
        logic [63:0] v;
        logic        e_data, e_crc, e_op, ok;
        int          c0, e0;
        cnt  = 0;
        ferr = 1'b0;
        for (int i = 0; i < 8; i++) bytes[i] = 8'd0;
        foreach (q_byte[i]) begin
            if (!q_stop[i]) ferr = 1'b1;
            else begin
                if (cnt < 8) bytes[cnt] = q_byte[i];
                cnt = (cnt + 1 > 9) ? 9 : cnt + 1;
            end
        end
        for (int i = 0; i < 8; i++) v[63 - 8*i -: 8] = bytes[i];
        e_data = (cnt != 8) || ferr || !cmd_stop;
        e_crc  = !e_data && (crc != ref_crc(v[63:32], v[31:0], o));
        e_op   = !e_data && !e_crc && !(o inside {3'b000, 3'b001, 3'b100, 3'b101});
        ok     = !(e_data || e_crc || e_op);

        c0 = n_cmdp;
        e0 = n_errp;
        foreach (q_byte[i]) send_frame(1'b0, q_byte[i], q_stop[i]);
        send_frame(1'b1, {1'b0, o, crc}, cmd_stop);
        @(posedge clk);
        #1;
        chk({tag, ".early"}, {cmd_valid, err_valid}, 2'b00);
        @(negedge clk);
        sin = 1'b1;
        @(posedge clk);
        #1;
        if (ok) begin
            exp_a  = v[31:0];
            exp_b  = v[63:32];
            exp_op = o;
        end
        chk({tag, ".cmd_valid"}, cmd_valid, ok);
        chk({tag, ".err_valid"}, err_valid, !ok);
        chk({tag, ".err_flags"}, err_flags, {e_data, e_crc, e_op});
        chk({tag, ".a"}, a, exp_a);
        chk({tag, ".b"}, b, exp_b);
        chk({tag, ".op"}, op, exp_op);
        @(posedge clk);
        #1;
        chk({tag, ".late"}, {cmd_valid, err_valid, err_flags}, 5'd0);
        chk({tag, ".npulse"}, {n_cmdp - c0, n_errp - e0}, {ok ? 32'd1 : 32'd0, ok ? 32'd0 : 32'd1});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        logic [3:0]  rc;
        int          kind, c0;

        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outs", {a, b, op, cmd_valid, err_valid, err_flags}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("idle.pulses", {n_cmdp, n_errp}, 0);
        chk("idle.outs", {a, b, op, cmd_valid, err_valid, err_flags}, 0);

        load_ab(32'h00000002, 32'h00000001);
        do_command("good_add", 3'b100, ref_crc(32'h2, 32'h1, 3'b100), 1'b1);

        load_ab(32'hDEADBEEF, 32'h01234567);
        void'(q_byte.pop_back());
        void'(q_stop.pop_back());
        do_command("short", 3'b000, ref_crc(32'hDEADBEEF, 32'h01234567, 3'b000), 1'b1);

        load_ab(32'h12345678, 32'hFFFFFFFF);
        do_command("crc_err", 3'b101, ~ref_crc(32'h12345678, 32'hFFFFFFFF, 3'b101), 1'b1);

        load_ab(32'h0BADF00D, 32'hCAFEBABE);
        do_command("bad_op", 3'b011, ref_crc(32'h0BADF00D, 32'hCAFEBABE, 3'b011), 1'b1);

        load_ab(32'h0FF00FF0, 32'hF0F0F0F0);
        do_command("good_and", 3'b000, ref_crc(32'h0FF00FF0, 32'hF0F0F0F0, 3'b000), 1'b1);

        load_ab(32'h11112222, 32'h33334444);
        q_byte.push_back(8'h55);
        q_stop.push_back(1'b1);
        do_command("overflow", 3'b001, ref_crc(32'h11112222, 32'h33334444, 3'b001), 1'b1);

        load_ab(32'hA5A5A5A5, 32'h5A5A5A5A);
        do_command("cmd_stop0", 3'b100, ref_crc(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b100), 1'b0);

        // Stop-bit error inside an otherwise good command.
        load_ab(32'h00C0FFEE, 32'h00000BAD);
        q_byte.insert(3, 8'h77);
        q_stop.insert(3, 1'b0);
        do_command("frame_err", 3'b100, ref_crc(32'h00C0FFEE, 32'h00000BAD, 3'b100), 1'b1);

        // Reset during the 5th DATA frame.
        c0 = n_cmdp;
        for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h3C, 1'b1);
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin = 1'b1;
        @(negedge clk); sin = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_a  = 32'd0;
        exp_b  = 32'd0;
        exp_op = 3'd0;
        chk("midreset.outs", {a, b, op, cmd_valid, err_valid, err_flags}, 0);
        load_ab(32'h76543210, 32'h89ABCDEF);
        do_command("after_reset", 3'b101, ref_crc(32'h76543210, 32'h89ABCDEF, 3'b101), 1'b1);
        chk("midreset.one_cmd", n_cmdp - c0, 1);

        for (int it = 0; it < 20; it++) begin
            ra   = $urandom;
            rb   = $urandom;
            ro   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 4);
            rc   = ref_crc(rb, ra, ro);
            load_ab(rb, ra);
            case (kind)
                1: rc = rc ^ 4'($urandom_range(1, 15));
                2: begin void'(q_byte.pop_front()); void'(q_stop.pop_front()); end
                3: begin q_byte.push_back(8'($urandom)); q_stop.push_back(1'b1); end
                4: begin
                    q_byte.insert($urandom_range(0, 8), 8'($urandom));
                    q_stop.insert(0, 1'b0);
                end
                default: ;
            endcase
            do_command("random", ro, rc, 1'b1);
        end

        chk("never_both", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
